// File: rtl/cla_pkg.sv
// Shared types and sizing helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  typedef enum logic [1:0] {
    ADD  = 2'd0,
    SUB  = 2'd1,
    ADC  = 2'd2,
    RSVD = 2'd3
  } cla_op_t;

  typedef struct packed {
    logic N;
    logic Z;
    logic C;
    logic V;
  } cla_flags_t;

  // Bits resolved per pipeline stage.
  function automatic int cla_sw(input int group_w, input int gps);
    return group_w * gps;
  endfunction

  // Number of pipeline stages for a given operand width.
  function automatic int cla_nstages(input int width, input int group_w, input int gps);
    return width / (group_w * gps);
  endfunction

endpackage

// File: rtl/cla_group.sv
// One carry-lookahead group: sum bits plus group propagate/generate.
module cla_group #(
  parameter int GROUP_W = 4
) (
  input  logic [GROUP_W-1:0] a_i,
  input  logic [GROUP_W-1:0] b_i,
  input  logic               c_i,
  output logic [GROUP_W-1:0] s_o,
  output logic               p_o,
  output logic               g_o
);

  logic [GROUP_W-1:0] p;
  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] c;
  logic               t_c;
  logic               t_g;

  assign p   = a_i ^ b_i;
  assign g   = a_i & b_i;
  assign s_o = p ^ c;
  assign p_o = &p;

  // Per-bit carries as flat sum-of-products over c_i, g and p (no ripple chain).
  always_comb begin
    c   = '0;
    t_c = 1'b0;
    for (int i = 0; i < GROUP_W; i++) begin
      t_c = c_i;
      for (int j = 0; j < i; j++) t_c = t_c & p[j];
      c[i] = t_c;
      for (int j = 0; j < i; j++) begin
        t_c = g[j];
        for (int m = j + 1; m < i; m++) t_c = t_c & p[m];
        c[i] = c[i] | t_c;
      end
    end
  end

  // Group generate: some bit generates and every bit above it propagates.
  always_comb begin
    g_o = 1'b0;
    t_g = 1'b0;
    for (int j = 0; j < GROUP_W; j++) begin
      t_g = g[j];
      for (int m = j + 1; m < GROUP_W; m++) t_g = t_g & p[m];
      g_o = g_o | t_g;
    end
  end

endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready on both sides
// and N/Z/C/V flags. Each stage resolves one SW-bit slice; the carry between
// slices is registered, upper operand bits ride along to later stages and
// finished low result bits ride along so S leaves aligned.
module pipe_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int GROUP_W = 4,
  parameter int GPS     = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  cla_op_t          op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output cla_flags_t       flags
);

  localparam int SW      = cla_sw(GROUP_W, GPS);
  localparam int NSTAGES = cla_nstages(WIDTH, GROUP_W, GPS);
  localparam int LAST    = NSTAGES - 1;

  if ((WIDTH % SW) != 0 || NSTAGES < 1) begin : g_bad_width
    $error("pipe_cla_adder: WIDTH must be a positive multiple of GROUP_W*GPS");
  end

  // Stage registers: operands, partial result, slice carry, running zero bit.
  logic [WIDTH-1:0]   a_q [NSTAGES];
  logic [WIDTH-1:0]   b_q [NSTAGES];
  logic [WIDTH-1:0]   s_q [NSTAGES];
  logic               c_q [NSTAGES];
  logic               z_q [NSTAGES];
  logic [NSTAGES-1:0] vld_q;
  cla_flags_t         flags_q;
  cla_flags_t         flags_d;

  // Stage inputs (from ports or previous stage) and stage results.
  logic [WIDTH-1:0]   in_a [NSTAGES];
  logic [WIDTH-1:0]   in_b [NSTAGES];
  logic [WIDTH-1:0]   in_s [NSTAGES];
  logic               in_c [NSTAGES];
  logic               in_z [NSTAGES];
  logic [NSTAGES-1:0] in_v;
  logic [WIDTH-1:0]   nx_s [NSTAGES];
  logic               nx_c [NSTAGES];
  logic               nx_z [NSTAGES];
  logic [NSTAGES-1:0] en;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stg
    logic [GPS-1:0]   gp;
    logic [GPS-1:0]   gg;
    logic [GPS:0]     gc;
    logic [SW-1:0]    sum;
    logic [WIDTH-1:0] s_next;
    logic             t;

    if (k == 0) begin : g_entry
      // Stage 0 boundary: B inverted and carry-in chosen from op here.
      assign in_a[k] = A;
      assign in_b[k] = (op == SUB) ? ~B : B;
      assign in_c[k] = (op == SUB) | ((op == ADC) & cin);
      assign in_s[k] = '0;
      assign in_z[k] = 1'b1;
      assign in_v[k] = in_valid;
    end else begin : g_link
      // Stage k boundary: everything comes from the stage k-1 register.
      assign in_a[k] = a_q[k-1];
      assign in_b[k] = b_q[k-1];
      assign in_c[k] = c_q[k-1];
      assign in_s[k] = s_q[k-1];
      assign in_z[k] = z_q[k-1];
      assign in_v[k] = vld_q[k-1];
    end

    for (genvar j = 0; j < GPS; j++) begin : g_grp
      cla_group #(
        .GROUP_W(GROUP_W)
      ) u_grp (
        .a_i(in_a[k][k*SW + j*GROUP_W +: GROUP_W]),
        .b_i(in_b[k][k*SW + j*GROUP_W +: GROUP_W]),
        .c_i(gc[j]),
        .s_o(sum[j*GROUP_W +: GROUP_W]),
        .p_o(gp[j]),
        .g_o(gg[j])
      );
    end

    // Group carries across the stage, flattened so no group waits on another.
    always_comb begin
      gc = '0;
      t  = 1'b0;
      for (int i = 0; i <= GPS; i++) begin
        t = in_c[k];
        for (int j = 0; j < i; j++) t = t & gp[j];
        gc[i] = t;
        for (int j = 0; j < i; j++) begin
          t = gg[j];
          for (int m = j + 1; m < i; m++) t = t & gp[m];
          gc[i] = gc[i] | t;
        end
      end
    end

    // Merge this stage's slice into the aligned partial result.
    always_comb begin
      s_next                = in_s[k];
      s_next[k*SW +: SW]    = sum;
    end

    assign nx_s[k] = s_next;
    assign nx_c[k] = gc[GPS];
    assign nx_z[k] = in_z[k] & ~(|sum);
  end

  // Flags come from the final slice: carry into MSB recovered from s^a^b.
  always_comb begin
    flags_d   = '0;
    flags_d.N = nx_s[LAST][WIDTH-1];
    flags_d.Z = nx_z[LAST];
    flags_d.C = nx_c[LAST];
    flags_d.V = (nx_s[LAST][WIDTH-1] ^ in_a[LAST][WIDTH-1] ^ in_b[LAST][WIDTH-1]) ^ nx_c[LAST];
  end

  // Load enables: a stage loads when empty or when its successor loads.
  always_comb begin
    en       = '0;
    en[LAST] = !vld_q[LAST] || out_ready;
    for (int k = LAST - 1; k >= 0; k--) en[k] = !vld_q[k] || en[k+1];
  end

  // Valid bits: the only control state; cleared by Reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_q <= '0;
    end else begin
      for (int k = 0; k < NSTAGES; k++) begin
        if (en[k]) vld_q[k] <= in_v[k];
      end
    end
  end

  // Stage data loads only with a real item, so bubbles never disturb S/flags.
  always_ff @(posedge Clk) begin
    for (int k = 0; k < NSTAGES; k++) begin
      if (en[k] && in_v[k]) begin
        a_q[k] <= in_a[k];
        b_q[k] <= in_b[k];
        s_q[k] <= nx_s[k];
        c_q[k] <= nx_c[k];
        z_q[k] <= nx_z[k];
      end
    end
    if (en[LAST] && in_v[LAST]) flags_q <= flags_d;
    if (Reset) begin
      s_q[LAST] <= '0;
      flags_q   <= '0;
    end
  end

  // The final stage's operand/carry copies have no consumer.
  logic unused_tail;
  assign unused_tail = ^{a_q[LAST], b_q[LAST], c_q[LAST], z_q[LAST]};

  assign in_ready  = en[0];
  assign out_valid = vld_q[LAST];
  assign S         = s_q[LAST];
  assign flags     = flags_q;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Scoreboard bench for pipe_cla_adder at WIDTH=16, GROUP_W=4, GPS=2.
module tb_pipe_cla_adder;
  import cla_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  cla_op_t     op;
  logic [15:0] A;
  logic [15:0] B;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] S;
  cla_flags_t  flags;

  typedef struct {
    logic [15:0] s;
    logic [3:0]  f;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   rnd_rdy = 0;

  pipe_cla_adder #(
    .WIDTH(16),
    .GROUP_W(4),
    .GPS(2)
  ) dut (
    .Clk(clk),
    .Reset(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .A(A),
    .B(B),
    .cin(cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .S(S),
    .flags(flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every output transfer is popped and compared in order.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_output: got S=%h flags=%b, required no output", S, flags);
        n_err++;
      end else begin
        e = exp_q.pop_front();
        if (S !== e.s || flags !== e.f) begin
          $display("FAIL result: got S=%h flags=%b, required S=%h flags=%b", S, flags, e.s, e.f);
          n_err++;
        end
        if (e.lat) begin
          n_cmp++;
          if (cyc - e.acc != 2) begin
            $display("FAIL latency: got %0d cycles, required 2", cyc - e.acc);
            n_err++;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      $display("FAIL %s: got %h, required %h", nm, act, req);
      n_err++;
    end
  endtask

  // Presents one operation and pushes its expected result when accepted.
  task automatic send(input cla_op_t o, input logic [15:0] a, input logic [15:0] b,
                      input logic c, input logic [15:0] es, input logic [3:0] ef,
                      input bit lat);
    int n;
    op = o; A = a; B = b; cin = c; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, required 1");
    end else begin
      exp_q.push_back('{es, ef, cyc, lat});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] model(input cla_op_t o, input logic [15:0] a,
                                        input logic [15:0] b, input logic ci);
    logic [15:0] bb;
    logic [16:0] r;
    logic        c0;
    bb = (o == SUB) ? ~b : b;
    c0 = (o == SUB) ? 1'b1 : ((o == ADC) ? ci : 1'b0);
    r  = {1'b0, a} + {1'b0, bb} + {16'd0, c0};
    return {r[15:0], r[15], (r[15:0] == 16'd0), r[16], (a[15] == bb[15]) && (r[15] != a[15])};
  endfunction

  initial begin
    cla_op_t     ro;
    logic [15:0] ra, rb;
    logic        rc;
    logic [19:0] m;
    int          n;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = ADD; A = '0; B = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_S", 32'(S), 32'd0);
    chk("reset_flags", 32'(flags), 32'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;

    // Overflow, subtract, carry-in handling.
    send(ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b1001, 1);
    idle(); idle(); idle();
    send(SUB, 16'h1234, 16'h1234, 1'b0, 16'h0000, 4'b0110, 1);
    send(SUB, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 4'b1000, 1);
    send(ADC, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 4'b0110, 1);
    send(ADD, 16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 4'b1000, 1);
    idle(); idle(); idle();

    // Eight back-to-back ops.
    send(ADD,  16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000, 1);
    send(SUB,  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b0011, 1);
    send(ADC,  16'h00FF, 16'h0001, 1'b0, 16'h0100, 4'b0000, 1);
    send(ADC,  16'h00FF, 16'h0001, 1'b1, 16'h0101, 4'b0000, 1);
    send(RSVD, 16'h4000, 16'h4000, 1'b1, 16'h8000, 4'b1001, 1);
    send(ADD,  16'h8000, 16'h8000, 1'b0, 16'h0000, 4'b0111, 1);
    send(SUB,  16'h0005, 16'h0007, 1'b0, 16'hFFFE, 4'b1000, 1);
    send(ADD,  16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 4'b0000, 1);
    idle(); idle(); idle();

    // Backpressure: two accepted, then in_ready must stay low.
    out_ready = 1'b0;
    send(ADD, 16'h1111, 16'h2222, 1'b0, 16'h3333, 4'b0000, 0);
    send(SUB, 16'h0010, 16'h0020, 1'b0, 16'hFFF0, 4'b1000, 0);
    op = ADC; A = 16'h7FFF; B = 16'h0000; cin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(ADC, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 4'b1001, 0);
    send(ADD, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 4'b1010, 0);
    idle(); idle(); idle();

    // Reset with two ops in flight.
    out_ready = 1'b0;
    send(ADD, 16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000, 0);
    send(ADD, 16'h0002, 16'h0002, 1'b0, 16'h0004, 4'b0000, 0);
    idle();
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_S", 32'(S), 32'd0);
    chk("flush_flags", 32'(flags), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_no_stale", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end

    // Random traffic with random valid gaps and random out_ready.
    rnd_rdy = 1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      ro = cla_op_t'($urandom_range(0, 3));
      ra = 16'($urandom());
      rb = 16'($urandom());
      rc = 1'($urandom_range(0, 1));
      m  = model(ro, ra, rb, rc);
      send(ro, ra, rb, rc, m[19:4], m[3:0], 0);
    end
    in_valid = 1'b0;
    rnd_rdy  = 0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
